// File: rtl/uart_fifo_conn.sv
// uart_fifo_conn: UART with TX/RX FIFOs, configurable framing and sticky error status
module uart_fifo_conn_fifo #(
  parameter int W = 8,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem_q [D];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_pop, do_push;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (AW+1)'(D);
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o = mem_q[rd_q];
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

module uart_fifo_conn #(
  parameter int DATA_W = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic              err_clr,
  output logic [5:0]        status,
  input  logic              rxd,
  output logic              txd
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} st_e;
  st_e tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [3:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, txf_dout, rxf_dout;
  logic tx_par_q, tx_par_d, rx_par_q, rx_par_d, txd_q;
  logic tx_pop, tx_end, tx_last_data, tx_last_stop, txf_empty, txf_full;
  logic rx_s1_q, rx_s2_q, rx_prev_q, rx_end, rx_last_data, rx_push, rx_pop, rxf_empty, rxf_full;
  logic ferr_set, perr_set, ovr_set, ferr_q, perr_q, ovr_q;
  uart_fifo_conn_fifo #(.W(DATA_W), .D(TX_DEPTH)) u_txf (
    .clk(clk), .rst(rst), .push_i(tx_valid & tx_ready), .din_i(tx_data), .pop_i(tx_pop),
    .dout_o(txf_dout), .empty_o(txf_empty), .full_o(txf_full));
  uart_fifo_conn_fifo #(.W(DATA_W), .D(RX_DEPTH)) u_rxf (
    .clk(clk), .rst(rst), .push_i(rx_push), .din_i(rx_sh_q), .pop_i(rx_pop),
    .dout_o(rxf_dout), .empty_o(rxf_empty), .full_o(rxf_full));
  assign tx_ready = ~txf_full;
  assign rx_valid = ~rxf_empty;
  assign rx_pop = rx_valid & rx_ready;
  assign rx_data = rx_valid ? rxf_dout : '0;
  assign txd = txd_q;
  assign status = {ovr_q, perr_q, ferr_q, rxf_full, txf_empty & (tx_st_q == IDLE), tx_st_q != IDLE};
  assign tx_end = tx_cnt_q == CW'(CLKS_PER_BIT - 1);
  assign tx_last_data = tx_bit_q == 4'(DATA_W - 1);
  assign tx_last_stop = tx_bit_q == 4'(STOP_BITS - 1);
  assign rx_end = rx_cnt_q == CW'(CLKS_PER_BIT - 1);
  assign rx_last_data = rx_bit_q == 4'(DATA_W - 1);
  assign ovr_set = rx_push & rxf_full & ~rx_pop;
  always_comb begin
    tx_st_d = tx_st_q;
    tx_cnt_d = tx_end ? '0 : tx_cnt_q + CW'(1);
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    tx_par_d = tx_par_q;
    tx_pop = 1'b0;
    case (tx_st_q)
      IDLE: begin
        tx_cnt_d = '0;
        tx_pop = ~txf_empty;
      end
      START: if (tx_end) tx_st_d = DATA;
      DATA: if (tx_end) begin
        tx_sh_d = tx_sh_q >> 1;
        tx_bit_d = tx_last_data ? '0 : tx_bit_q + 4'd1;
        if (tx_last_data) tx_st_d = PARITY != 0 ? PAR : STOP;
      end
      PAR: if (tx_end) tx_st_d = STOP;
      STOP: if (tx_end) begin
        tx_bit_d = tx_last_stop ? '0 : tx_bit_q + 4'd1;
        if (tx_last_stop) begin
          tx_st_d = IDLE;
          tx_pop = ~txf_empty;
        end
      end
      default: tx_st_d = IDLE;
    endcase
    // a pop from IDLE or the final stop period starts the next frame with no gap
    if (tx_pop) begin
      tx_st_d = START;
      tx_sh_d = txf_dout;
      tx_par_d = ^txf_dout ^ (PARITY == 1);
    end
  end
  always_comb begin
    rx_st_d = rx_st_q;
    rx_cnt_d = rx_end ? '0 : rx_cnt_q + CW'(1);
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_par_d = rx_par_q;
    rx_push = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
    case (rx_st_q)
      IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q & ~rx_s2_q) rx_st_d = START;
      end
      START: if (rx_cnt_q == CW'(CLKS_PER_BIT / 2 - 1)) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d = rx_s2_q ? IDLE : DATA;
      end
      DATA: if (rx_end) begin
        rx_sh_d = {rx_s2_q, rx_sh_q[DATA_W-1:1]};
        rx_bit_d = rx_last_data ? '0 : rx_bit_q + 4'd1;
        if (rx_last_data) rx_st_d = PARITY != 0 ? PAR : STOP;
      end
      PAR: if (rx_end) begin
        rx_par_d = rx_s2_q;
        rx_st_d = STOP;
      end
      STOP: if (rx_end) begin
        rx_st_d = IDLE;
        ferr_set = ~rx_s2_q;
        perr_set = rx_s2_q & (PARITY != 0) & (rx_par_q != (^rx_sh_q ^ (PARITY == 1)));
        rx_push = rx_s2_q & ~perr_set;
      end
      default: rx_st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      tx_st_q <= IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      tx_par_q <= 1'b0;
      txd_q <= 1'b1;
      rx_st_q <= IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      rx_par_q <= 1'b0;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_prev_q <= 1'b1;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      tx_st_q <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d;
      tx_par_q <= tx_par_d;
      txd_q <= tx_st_q == START ? 1'b0 : tx_st_q == DATA ? tx_sh_q[0] : tx_st_q == PAR ? tx_par_q : 1'b1;
      rx_st_q <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      rx_par_q <= rx_par_d;
      rx_s1_q <= rxd;
      rx_s2_q <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      ferr_q <= ferr_set | (ferr_q & ~err_clr);
      perr_q <= perr_set | (perr_q & ~err_clr);
      ovr_q <= ovr_set | (ovr_q & ~err_clr);
    end
endmodule
